alu_exec: RTL and testbench

//   Integer execution unit at the consumer end of the reservation-station dispatch port.
//   - Accepts one ready RV32I non-memory instruction per cycle (FU_* bundle).
//   - Computes the result and resolves branches/jumps.
//   - Broadcasts {RobId, value, jump info} on the exc_* CDB port, read by RS, LSB and ROB.
//   - Latency is one registered stage; there is no backpressure.

---
 rtl/alu_exec.sv | 154 +++++++++++++++
 tb/tb_alu_exec.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/alu_exec.sv
// alu_exec: RV32I integer execution unit that broadcasts results on the CDB port.
// Latency: one registered stage. Result appears the cycle after FU_enable, one result per cycle.
// Backpressure: none. rdy=0 freezes all state and jump_flag flushes the dispatched instruction.
module alu_exec #(
  parameter int ROB_LOG = 4,
  parameter int OP_LOG  = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               rdy,
  input  logic               jump_flag,
  input  logic               FU_enable,
  input  logic [OP_LOG-1:0]  FU_op,
  input  logic [31:0]        FU_Vj,
  input  logic [31:0]        FU_Vk,
  input  logic [31:0]        FU_Imm,
  input  logic [ROB_LOG-1:0] FU_DestRob,
  input  logic [31:0]        FU_CurPC,
  output logic               exc_valid,
  output logic [ROB_LOG-1:0] exc_RobId,
  output logic [31:0]        exc_value,
  output logic               exc_jump,
  output logic [31:0]        exc_target,
  output logic [31:0]        exec_count
);

  // Op encodings. Code 0 and anything above BGEU decode as unknown:
  // the instruction is still broadcast so that its ROB entry retires.
  localparam logic [OP_LOG-1:0] OP_ADD   = OP_LOG'(1);
  localparam logic [OP_LOG-1:0] OP_SUB   = OP_LOG'(2);
  localparam logic [OP_LOG-1:0] OP_AND   = OP_LOG'(3);
  localparam logic [OP_LOG-1:0] OP_OR    = OP_LOG'(4);
  localparam logic [OP_LOG-1:0] OP_XOR   = OP_LOG'(5);
  localparam logic [OP_LOG-1:0] OP_SLT   = OP_LOG'(6);
  localparam logic [OP_LOG-1:0] OP_SLTU  = OP_LOG'(7);
  localparam logic [OP_LOG-1:0] OP_SLL   = OP_LOG'(8);
  localparam logic [OP_LOG-1:0] OP_SRL   = OP_LOG'(9);
  localparam logic [OP_LOG-1:0] OP_SRA   = OP_LOG'(10);
  localparam logic [OP_LOG-1:0] OP_ADDI  = OP_LOG'(11);
  localparam logic [OP_LOG-1:0] OP_ANDI  = OP_LOG'(12);
  localparam logic [OP_LOG-1:0] OP_ORI   = OP_LOG'(13);
  localparam logic [OP_LOG-1:0] OP_XORI  = OP_LOG'(14);
  localparam logic [OP_LOG-1:0] OP_SLTI  = OP_LOG'(15);
  localparam logic [OP_LOG-1:0] OP_SLTIU = OP_LOG'(16);
  localparam logic [OP_LOG-1:0] OP_SLLI  = OP_LOG'(17);
  localparam logic [OP_LOG-1:0] OP_SRLI  = OP_LOG'(18);
  localparam logic [OP_LOG-1:0] OP_SRAI  = OP_LOG'(19);
  localparam logic [OP_LOG-1:0] OP_LUI   = OP_LOG'(20);
  localparam logic [OP_LOG-1:0] OP_AUIPC = OP_LOG'(21);
  localparam logic [OP_LOG-1:0] OP_JAL   = OP_LOG'(22);
  localparam logic [OP_LOG-1:0] OP_JALR  = OP_LOG'(23);
  localparam logic [OP_LOG-1:0] OP_BEQ   = OP_LOG'(24);
  localparam logic [OP_LOG-1:0] OP_BNE   = OP_LOG'(25);
  localparam logic [OP_LOG-1:0] OP_BLT   = OP_LOG'(26);
  localparam logic [OP_LOG-1:0] OP_BGE   = OP_LOG'(27);
  localparam logic [OP_LOG-1:0] OP_BLTU  = OP_LOG'(28);
  localparam logic [OP_LOG-1:0] OP_BGEU  = OP_LOG'(29);

  logic               valid_q;
  logic [ROB_LOG-1:0] rob_q;
  logic [31:0]        value_q, value_d;
  logic               jump_q, jump_d;
  logic [31:0]        target_q, target_d;
  logic [31:0]        count_q;

  logic        is_imm;
  logic [31:0] a, b, pc4, pc_imm, sra_res;
  logic [4:0]  shamt;
  logic        lt_s, lt_u, eq;

  // Operand selection and shared comparators/adders.
  always_comb begin
    is_imm  = (FU_op >= OP_ADDI) && (FU_op <= OP_SRAI);
    a       = FU_Vj;
    b       = is_imm ? FU_Imm : FU_Vk;
    shamt   = b[4:0];
    pc4     = FU_CurPC + 32'd4;
    pc_imm  = FU_CurPC + FU_Imm;
    lt_s    = $signed(a) < $signed(b);
    lt_u    = a < b;
    eq      = (a == b);
    sra_res = $unsigned($signed(a) >>> shamt);
  end

  // Result, jump resolution and next-PC target for the dispatched op.
  always_comb begin
    value_d  = 32'd0;
    jump_d   = 1'b0;
    target_d = pc4;
    case (FU_op)
      OP_ADD,  OP_ADDI:  value_d = a + b;
      OP_SUB:            value_d = a - b;
      OP_AND,  OP_ANDI:  value_d = a & b;
      OP_OR,   OP_ORI:   value_d = a | b;
      OP_XOR,  OP_XORI:  value_d = a ^ b;
      OP_SLT,  OP_SLTI:  value_d = {31'd0, lt_s};
      OP_SLTU, OP_SLTIU: value_d = {31'd0, lt_u};
      OP_SLL,  OP_SLLI:  value_d = a << shamt;
      OP_SRL,  OP_SRLI:  value_d = a >> shamt;
      OP_SRA,  OP_SRAI:  value_d = sra_res;
      OP_LUI:            value_d = FU_Imm;
      OP_AUIPC:          value_d = pc_imm;
      OP_JAL: begin
        value_d  = pc4;
        jump_d   = 1'b1;
        target_d = pc_imm;
      end
      OP_JALR: begin
        value_d  = pc4;
        jump_d   = 1'b1;
        target_d = (FU_Vj + FU_Imm) & ~32'd1;
      end
      OP_BEQ:  jump_d = eq;
      OP_BNE:  jump_d = ~eq;
      OP_BLT:  jump_d = lt_s;
      OP_BGE:  jump_d = ~lt_s;
      OP_BLTU: jump_d = lt_u;
      OP_BGEU: jump_d = ~lt_u;
      default: ;
    endcase
    if (jump_d && (FU_op != OP_JAL) && (FU_op != OP_JALR)) target_d = pc_imm;
  end

  // Output stage: flush beats freeze, freeze beats normal issue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      rob_q    <= '0;
      value_q  <= 32'd0;
      jump_q   <= 1'b0;
      target_q <= 32'd0;
      count_q  <= 32'd0;
    end else if (jump_flag) begin
      valid_q <= 1'b0;
    end else if (rdy) begin
      valid_q <= FU_enable;
      if (FU_enable) begin
        rob_q    <= FU_DestRob;
        value_q  <= value_d;
        jump_q   <= jump_d;
        target_q <= target_d;
        count_q  <= count_q + 32'd1;
      end
    end
  end

  assign exc_valid  = valid_q;
  assign exc_RobId  = rob_q;
  assign exc_value  = value_q;
  assign exc_jump   = jump_q;
  assign exc_target = target_q;
  assign exec_count = count_q;

endmodule

// File: tb/tb_alu_exec.sv
// Directed testbench for alu_exec with hand-computed expected values.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled at the same point.
module tb_alu_exec;

  localparam logic [4:0] OP_NOP   = 5'd0;
  localparam logic [4:0] OP_ADD   = 5'd1;
  localparam logic [4:0] OP_SUB   = 5'd2;
  localparam logic [4:0] OP_SLT   = 5'd6;
  localparam logic [4:0] OP_SLTU  = 5'd7;
  localparam logic [4:0] OP_SRA   = 5'd10;
  localparam logic [4:0] OP_ADDI  = 5'd11;
  localparam logic [4:0] OP_XORI  = 5'd14;
  localparam logic [4:0] OP_SLLI  = 5'd17;
  localparam logic [4:0] OP_LUI   = 5'd20;
  localparam logic [4:0] OP_AUIPC = 5'd21;
  localparam logic [4:0] OP_JAL   = 5'd22;
  localparam logic [4:0] OP_JALR  = 5'd23;
  localparam logic [4:0] OP_BLT   = 5'd26;
  localparam logic [4:0] OP_BLTU  = 5'd28;
  localparam logic [4:0] OP_BGEU  = 5'd29;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rdy = 1'b1;
  logic        jump_flag = 1'b0;
  logic        FU_enable = 1'b0;
  logic [4:0]  FU_op = '0;
  logic [31:0] FU_Vj = '0, FU_Vk = '0, FU_Imm = '0, FU_CurPC = '0;
  logic [3:0]  FU_DestRob = '0;
  logic        exc_valid, exc_jump;
  logic [3:0]  exc_RobId;
  logic [31:0] exc_value, exc_target, exec_count;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_count = 32'd0;

  alu_exec #(.ROB_LOG(4), .OP_LOG(5)) dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .jump_flag(jump_flag),
    .FU_enable(FU_enable), .FU_op(FU_op), .FU_Vj(FU_Vj), .FU_Vk(FU_Vk),
    .FU_Imm(FU_Imm), .FU_DestRob(FU_DestRob), .FU_CurPC(FU_CurPC),
    .exc_valid(exc_valid), .exc_RobId(exc_RobId), .exc_value(exc_value),
    .exc_jump(exc_jump), .exc_target(exc_target), .exec_count(exec_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Present one instruction for one edge, then sample the registered result.
  task automatic issue(input logic [4:0] op, input logic [31:0] vj, input logic [31:0] vk,
                       input logic [31:0] imm, input logic [3:0] rob, input logic [31:0] pc);
    FU_enable = 1'b1; FU_op = op; FU_Vj = vj; FU_Vk = vk;
    FU_Imm = imm; FU_DestRob = rob; FU_CurPC = pc;
    @(posedge clk); #1;
    FU_enable = 1'b0;
    if (rdy && !jump_flag) exp_count = exp_count + 32'd1;
  endtask

  // Compare the whole broadcast bundle against the expected result.
  task automatic expect_res(input string tag, input logic [3:0] rob, input logic [31:0] val,
                            input logic jmp, input logic [31:0] tgt);
    check({tag, ".valid"},  {31'd0, exc_valid}, 32'd1);
    check({tag, ".rob"},    {28'd0, exc_RobId}, {28'd0, rob});
    check({tag, ".value"},  exc_value, val);
    check({tag, ".jump"},   {31'd0, exc_jump}, {31'd0, jmp});
    check({tag, ".target"}, exc_target, tgt);
    check({tag, ".count"},  exec_count, exp_count);
  endtask

  initial begin
    // Reset state
    #2;
    check("rst.valid",  {31'd0, exc_valid}, 32'd0);
    check("rst.value",  exc_value, 32'd0);
    check("rst.target", exc_target, 32'd0);
    check("rst.count",  exec_count, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle.valid", {31'd0, exc_valid}, 32'd0);

    // Basic ALU ops
    issue(OP_ADD, 32'd7, 32'd5, 32'd0, 4'd3, 32'h40);
    expect_res("add", 4'd3, 32'd12, 1'b0, 32'h44);
    check("add.count1", exec_count, 32'd1);
    issue(OP_SUB, 32'd0, 32'd1, 32'd0, 4'd4, 32'h44);
    expect_res("sub", 4'd4, 32'hFFFF_FFFF, 1'b0, 32'h48);
    issue(OP_SRA, 32'h8000_0000, 32'h21, 32'd0, 4'd5, 32'h48);
    expect_res("sra", 4'd5, 32'hC000_0000, 1'b0, 32'h4C);
    issue(OP_SLTU, 32'd1, 32'hFFFF_FFFF, 32'd0, 4'd6, 32'h4C);
    expect_res("sltu", 4'd6, 32'd1, 1'b0, 32'h50);
    issue(OP_SLT, 32'd1, 32'hFFFF_FFFF, 32'd0, 4'd7, 32'h50);
    expect_res("slt", 4'd7, 32'd0, 1'b0, 32'h54);
    // Immediate form uses Imm, not Vk; only Imm[4:0] is the shift amount
    issue(OP_SLLI, 32'h3, 32'hFFFF_FFFF, 32'h24, 4'd8, 32'h54);
    expect_res("slli", 4'd8, 32'h30, 1'b0, 32'h58);
    issue(OP_LUI, 32'h1234, 32'd0, 32'hABCD_E000, 4'd9, 32'h58);
    expect_res("lui", 4'd9, 32'hABCD_E000, 1'b0, 32'h5C);
    issue(OP_AUIPC, 32'd0, 32'd0, 32'h0000_1000, 4'd10, 32'h5C);
    expect_res("auipc", 4'd10, 32'h105C, 1'b0, 32'h60);

    // Branches: -1 vs 0
    issue(OP_BLT, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFF8, 4'd11, 32'h100);
    expect_res("blt", 4'd11, 32'd0, 1'b1, 32'hF8);
    issue(OP_BLTU, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFF8, 4'd12, 32'h100);
    expect_res("bltu", 4'd12, 32'd0, 1'b0, 32'h104);
    issue(OP_BGEU, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFF8, 4'd13, 32'h100);
    expect_res("bgeu", 4'd13, 32'd0, 1'b1, 32'hF8);

    // Jumps, including PC+4 wrap
    issue(OP_JALR, 32'h1001, 32'd0, 32'd2, 4'd14, 32'h20);
    expect_res("jalr", 4'd14, 32'h24, 1'b1, 32'h1002);
    issue(OP_JAL, 32'd0, 32'd0, 32'd8, 4'd15, 32'hFFFF_FFFC);
    expect_res("jal", 4'd15, 32'd0, 1'b1, 32'h4);

    // Unknown op still broadcasts
    issue(OP_NOP, 32'd9, 32'd9, 32'd9, 4'd1, 32'h200);
    expect_res("unk", 4'd1, 32'd0, 1'b0, 32'h204);

    // Back-to-back dispatch
    issue(OP_ADDI, 32'd100, 32'd0, 32'hFFFF_FFFF, 4'd2, 32'h300);
    expect_res("b2b0", 4'd2, 32'd99, 1'b0, 32'h304);
    issue(OP_XORI, 32'hF0F0_F0F0, 32'd0, 32'hFFFF_FFFF, 4'd3, 32'h304);
    expect_res("b2b1", 4'd3, 32'h0F0F_0F0F, 1'b0, 32'h308);

    // Flush wins over dispatch; data outputs hold
    jump_flag = 1'b1;
    issue(OP_ADD, 32'd1, 32'd1, 32'd0, 4'd9, 32'h400);
    jump_flag = 1'b0;
    check("flush.valid", {31'd0, exc_valid}, 32'd0);
    check("flush.count", exec_count, exp_count);
    check("flush.value", exc_value, 32'h0F0F_0F0F);

    // Freeze: valid result, then rdy=0 for 3 cycles with dispatch attempts
    issue(OP_ADD, 32'd20, 32'd22, 32'd0, 4'd6, 32'h500);
    expect_res("prefrz", 4'd6, 32'd42, 1'b0, 32'h504);
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      issue(OP_SUB, 32'd1, 32'd2, 32'd0, 4'd7, 32'h600);
      expect_res($sformatf("frz%0d", i), 4'd6, 32'd42, 1'b0, 32'h504);
    end
    rdy = 1'b1;
    @(posedge clk); #1;
    check("unfrz.valid", {31'd0, exc_valid}, 32'd0);

    // Asynchronous reset between edges
    issue(OP_ADD, 32'd1, 32'd2, 32'd0, 4'd5, 32'h700);
    expect_res("prerst", 4'd5, 32'd3, 1'b0, 32'h704);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst.valid", {31'd0, exc_valid}, 32'd0);
    check("arst.count", exec_count, 32'd0);
    check("arst.value", exc_value, 32'd0);
    #2;
    rst_n = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
